// File: rtl/armleocpu_cache_arbiter.sv
// rtl/armleocpu_cache_arbiter.sv - shares one cache port between fetch and data requesters
// One outstanding cache operation; losing single-cycle pulses are buffered, ties alternate.
module armleocpu_cache_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  f_cmd,
  input  logic [31:0] f_address,
  output logic [3:0]  f_response,
  output logic [31:0] f_load_data,
  input  logic [3:0]  d_cmd,
  input  logic [31:0] d_address,
  input  logic [31:0] d_store_data,
  input  logic [3:0]  d_type,
  output logic [3:0]  d_response,
  output logic [31:0] d_load_data,
  output logic [3:0]  c_cmd,
  output logic [31:0] c_address,
  output logic [31:0] c_store_data,
  output logic [3:0]  c_type,
  input  logic [3:0]  c_response,
  input  logic [31:0] c_load_data,
  input  logic        c_reset_done
);

  localparam logic [3:0] CACHE_CMD_NONE             = 4'd0;
  localparam logic [3:0] CACHE_RESPONSE_IDLE        = 4'd0;
  localparam logic [3:0] CACHE_RESPONSE_WAIT        = 4'd1;
  localparam logic [3:0] CACHE_RESPONSE_DONE        = 4'd2;
  localparam logic [3:0] CACHE_RESPONSE_ACCESSFAULT = 4'd3;
  localparam logic [3:0] CACHE_RESPONSE_PAGEFAULT   = 4'd4;
  localparam logic [3:0] CACHE_RESPONSE_MISSALIGNED = 4'd5;

  typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_D} state_t;

  state_t      state;
  logic        last_grant;
  logic        f_pend_valid, d_pend_valid;
  logic [3:0]  f_pend_cmd, d_pend_cmd, d_pend_type;
  logic [31:0] f_pend_address, d_pend_address, d_pend_store_data;

  logic terminal, free, can_grant;
  logic f_live, d_live, f_cand, d_cand;
  logic grant_f, grant_d, f_capture, d_capture;

  always_comb begin
    terminal = (state != IDLE) &&
               ((c_response == CACHE_RESPONSE_DONE) ||
                (c_response == CACHE_RESPONSE_ACCESSFAULT) ||
                (c_response == CACHE_RESPONSE_MISSALIGNED) ||
                (c_response == CACHE_RESPONSE_PAGEFAULT));
    free      = (state == IDLE) || terminal;
    can_grant = free && c_reset_done;
    // A port may reissue only once its outstanding op delivers its terminal response
    f_live = (f_cmd != CACHE_CMD_NONE) && !f_pend_valid && !((state == BUSY_F) && !terminal);
    d_live = (d_cmd != CACHE_CMD_NONE) && !d_pend_valid && !((state == BUSY_D) && !terminal);
    f_cand = f_pend_valid || f_live;
    d_cand = d_pend_valid || d_live;
    grant_d   = can_grant && d_cand && (!f_cand || !last_grant);
    grant_f   = can_grant && f_cand && !grant_d;
    f_capture = f_live && !grant_f;
    d_capture = d_live && !grant_d;
  end

  always_comb begin
    c_cmd        = CACHE_CMD_NONE;
    c_address    = 32'd0;
    c_store_data = 32'd0;
    c_type       = 4'd0;
    if (grant_f) begin
      c_cmd     = f_pend_valid ? f_pend_cmd : f_cmd;
      c_address = f_pend_valid ? f_pend_address : f_address;
    end else if (grant_d) begin
      c_cmd        = d_pend_valid ? d_pend_cmd : d_cmd;
      c_address    = d_pend_valid ? d_pend_address : d_address;
      c_store_data = d_pend_valid ? d_pend_store_data : d_store_data;
      c_type       = d_pend_valid ? d_pend_type : d_type;
    end
  end

  always_comb begin
    f_response = CACHE_RESPONSE_IDLE;
    d_response = CACHE_RESPONSE_IDLE;
    if (state == BUSY_F)
      f_response = c_response;
    else if (f_pend_valid || f_capture)
      f_response = CACHE_RESPONSE_WAIT;
    if (state == BUSY_D)
      d_response = c_response;
    else if (d_pend_valid || d_capture)
      d_response = CACHE_RESPONSE_WAIT;
    f_load_data = c_load_data;
    d_load_data = c_load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      last_grant        <= 1'b0;
      f_pend_valid      <= 1'b0;
      f_pend_cmd        <= CACHE_CMD_NONE;
      f_pend_address    <= 32'd0;
      d_pend_valid      <= 1'b0;
      d_pend_cmd        <= CACHE_CMD_NONE;
      d_pend_address    <= 32'd0;
      d_pend_store_data <= 32'd0;
      d_pend_type       <= 4'd0;
    end else begin
      if (free) begin
        if (grant_f)      state <= BUSY_F;
        else if (grant_d) state <= BUSY_D;
        else              state <= IDLE;
      end
      if (grant_f)      last_grant <= 1'b0;
      else if (grant_d) last_grant <= 1'b1;

      if (grant_f) begin
        f_pend_valid <= 1'b0;
      end else if (f_capture) begin
        f_pend_valid   <= 1'b1;
        f_pend_cmd     <= f_cmd;
        f_pend_address <= f_address;
      end

      if (grant_d) begin
        d_pend_valid <= 1'b0;
      end else if (d_capture) begin
        d_pend_valid      <= 1'b1;
        d_pend_cmd        <= d_cmd;
        d_pend_address    <= d_address;
        d_pend_store_data <= d_store_data;
        d_pend_type       <= d_type;
      end
    end
  end

endmodule

// File: doc/armleocpu_cache_arbiter.md
# armleocpu_cache_arbiter

Shares one `armleocpu_cache` command/response port between the instruction fetch requester (`f_*`) and the execute-stage data requester (`d_*`). It sits between fetch/execute and the cache. It grants one outstanding cache operation at a time and buffers a losing requester's single-cycle command pulse. It routes the cache response back to the owning requester only, and alternates priority round-robin on contention.

## Interface
- No parameters. Command/response encodings are the `CACHE_CMD_*` / `CACHE_RESPONSE_*` macros from `armleocpu_cache.vh`.
- `clk` input 1: clock, all state on rising edge.
- `rst_n` input 1: reset; reset is asynchronous and active-low.
- `f_cmd` input 4: fetch command, one-cycle pulse; `CACHE_CMD_NONE` = no request.
- `f_address` input 32: fetch address, valid with `f_cmd`.
- `f_response` output 4: response seen by fetch.
- `f_load_data` output 32: load data to fetch.
- `d_cmd` input 4: data command, one-cycle pulse.
- `d_address` input 32: data address.
- `d_store_data` input 32: store data.
- `d_type` input 4: load/store type, forwarded unchanged.
- `d_response` output 4: response seen by data requester.
- `d_load_data` output 32: load data to data requester.
- `c_cmd` output 4: cache command.
- `c_address` output 32: cache address.
- `c_store_data` output 32: cache store data.
- `c_type` output 4: cache access type; 0 for fetch grants.
- `c_response` input 4: cache response.
- `c_load_data` input 32: cache load data.
- `c_reset_done` input 1: cache ready; no command is issued while low.

## Operation
- State: `IDLE`, `BUSY_F`, `BUSY_D`. Also per-port pending buffers `f_pend`/`d_pend` (valid + cmd + address, plus store data and type for d) and a `last_grant` bit (0 = fetch).
- Reset values: state `IDLE`, both pending valids 0, `last_grant` = 0. Outputs: `c_cmd` = NONE, `f_response`/`d_response` = IDLE.
- Candidate per port is its pending buffer if valid, else its live `*_cmd` if not NONE.
- Free cycle means any of:
  - state `IDLE`;
  - state `BUSY_*` with `c_response` DONE, ACCESSFAULT, MISSALIGNED or PAGEFAULT (terminal).
- On a free cycle with `c_reset_done` = 1:
  - Grant the single candidate.
  - If both ports are candidates, grant the port ≠ `last_grant`.
  - Drive `c_*` combinationally from the granted source in that same cycle.
  - Set state to `BUSY_F`/`BUSY_D`, update `last_grant`, and clear that port's pending valid.
  - With no candidate, go to `IDLE`.
- A live `*_cmd` that is not granted in its cycle is captured into that port's pending buffer.
- `*_cmd` from a port whose request is already pending or outstanding is a protocol violation and is ignored.
- Exception: a port may issue a new command in the same cycle its terminal response is delivered. That command is granted or captured as above.
- Response routing:
  - Owner port gets `c_response` verbatim.
  - A non-owner port with a pending request sees WAIT.
  - Otherwise a port sees IDLE.
  - `c_load_data` is broadcast to both `*_load_data`.
- In `BUSY_*`, `c_cmd` = NONE except in the terminal cycle when a new grant is issued.
- `c_reset_done` = 0: no grants and `c_cmd` = NONE; live commands are still captured; pending ports see WAIT.

## Timing
- Uncontended: zero added latency. Command pulse at cycle N → `c_cmd` at N; cache response at N+k → requester response at N+k, same cycle.
- Back-to-back: a same-cycle reissue on terminal response continues with no idle cycle, unless the other port is pending. Round-robin then grants the other port and buffers the reissue.
- Contended worst case: a requester waits at most one full operation of the other port.
- Async reset mid-operation: all state is cleared immediately. An in-flight cache response after reset is ignored because the state is `IDLE` (no owner).

## Test plan
- Fetch alone: `f_cmd`=EXECUTE, `f_address`=0x2000 at cycle 1. Expect `c_cmd`=EXECUTE/0x2000 in cycle 1. Cache returns WAIT×2 then DONE with 0x00000013 → `f_response` WAIT,WAIT,DONE and `f_load_data`=0x13; `d_response` stays IDLE.
- Simultaneous from reset: `f_cmd` EXECUTE 0x2000 and `d_cmd` LOAD 0x8000 in the same cycle. Expect data granted first (`c_address`=0x8000) and `f_response`=WAIT. On data DONE, fetch issues 0x2000 in the same cycle.
- Round-robin: data reissues on its own DONE while fetch is pending. Expect fetch granted, the data command buffered, and `d_response`=WAIT until fetch DONE; data then issues with the original address/store data 0xDEADBEEF.
- Error routing: cache returns PAGEFAULT to an outstanding data request. Expect `d_response`=PAGEFAULT for one cycle, `f_response` unaffected, state `IDLE` next cycle.
- `c_reset_done`=0 for 5 cycles with a fetch pulse in cycle 2. Expect `c_cmd` NONE throughout and `f_response` WAIT; on `c_reset_done` rising, the buffered command is issued that cycle.
- Assert `rst_n`=0 while `BUSY_D`. Expect all outputs at reset values immediately; a DONE arriving afterward produces no requester response.
